// File: rtl/branch_predict_unit.sv
// Branch target buffer with 2-bit saturating counters (fetch-side lookup) and
// execute-side branch/JAL/JALR resolution with redirect and performance counters.
module branch_predict_unit #(
    parameter int PC_W        = 9,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_alu_result,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             flag_halt,
    output logic [31:0]      pc_four,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W   = $clog2(BTB_ENTRIES);
    localparam bit HAS_TAG = (PC_W > IDX_W + 2);
    // A tagless configuration keeps a 1-bit tag field tied to zero so the match is always true.
    localparam int TAG_W   = HAS_TAG ? (PC_W - IDX_W - 2) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t           entry_flat [BTB_ENTRIES];
    entry_t           lookup_entry;
    entry_t           upd_entry;
    entry_t           entry_next;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    logic             if_hit;
    logic             upd_hit;
    logic             ctl;
    logic             actual_taken;
    logic [31:0]      actual_target;
    logic             mispredict;
    logic [CNT_W-1:0] br_count_reg;
    logic [CNT_W-1:0] mispred_count_reg;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^if_pc[1:0];

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    generate
        if (HAS_TAG) begin : g_tag
            assign if_tag = if_pc[PC_W-1:IDX_W+2];
            assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
        end else begin : g_notag
            assign if_tag = '0;
            assign ex_tag = '0;
        end
    endgenerate

    // Fetch lookup reads the registered table, so a same-cycle update is not visible here.
    assign lookup_entry = entry_flat[if_idx];
    assign if_hit       = lookup_entry.valid && (lookup_entry.tag == if_tag);
    assign pred_taken   = !reset && if_hit && lookup_entry.ctr[1];
    assign pred_target  = pred_taken ? 32'(lookup_entry.target) : 32'd0;

    assign ctl          = ex_valid && (ex_branch || ex_jal || ex_jalr) && !flag_halt;
    assign actual_taken = ex_jal || ex_jalr || (ex_branch && ex_alu_result[0]);

    always_comb begin
        actual_target = 32'(ex_pc) + ex_imm;
        if (ex_jalr) begin
            actual_target = {ex_alu_result[31:1], 1'b0};
        end
    end

    assign mispredict  = (actual_taken != ex_pred_taken) ||
                         (actual_taken && ex_pred_taken && (actual_target != ex_pred_target));
    assign pc_four     = flag_halt ? 32'd0 : (32'(ex_pc) + 32'd4);
    assign redirect    = !reset && ctl && mispredict;
    assign redirect_pc = redirect ? (actual_taken ? actual_target : pc_four) : 32'd0;

    assign upd_entry = entry_flat[ex_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == ex_tag);

    always_comb begin
        entry_next = upd_entry;
        if (upd_hit) begin
            if (actual_taken) begin
                entry_next.target = actual_target[PC_W-1:0];
                if (upd_entry.ctr != 2'b11) begin
                    entry_next.ctr = upd_entry.ctr + 2'd1;
                end
            end else if (upd_entry.ctr != 2'b00) begin
                entry_next.ctr = upd_entry.ctr - 2'd1;
            end
        end else if (actual_taken) begin
            entry_next.valid  = 1'b1;
            entry_next.tag    = ex_tag;
            entry_next.target = actual_target[PC_W-1:0];
            // Unconditional jumps start strongly taken; branches start weakly taken.
            entry_next.ctr    = (ex_jal || ex_jalr) ? 2'b11 : 2'b10;
        end
    end

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
            entry_t entry_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg.valid  <= 1'b0;
                    entry_reg.tag    <= '0;
                    entry_reg.target <= '0;
                    entry_reg.ctr    <= 2'b01;
                end else if (ctl && (ex_idx == IDX_W'(gi))) begin
                    entry_reg <= entry_next;
                end
            end
            assign entry_flat[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else if (ctl) begin
            br_count_reg <= br_count_reg + CNT_W'(1);
            if (mispredict) begin
                mispred_count_reg <= mispred_count_reg + CNT_W'(1);
            end
        end
    end

    assign br_count      = br_count_reg;
    assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: each scenario task drives a few
// transactions and compares outputs against hand-computed values.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch;
    logic        ex_jal;
    logic        ex_jalr;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flag_halt;
    logic [31:0] pc_four;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int errors = 0;
    int checks = 0;

    branch_predict_unit #(.PC_W(9), .BTB_ENTRIES(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_alu_result(ex_alu_result), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .flag_halt(flag_halt),
        .pc_four(pc_four), .redirect(redirect), .redirect_pc(redirect_pc),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic drive_ex(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                            input logic b, input logic j, input logic jr, input logic [31:0] alu,
                            input logic pt, input logic [31:0] ptg, input logic halt);
        ex_valid = v; ex_pc = pc; ex_imm = imm; ex_branch = b; ex_jal = j; ex_jalr = jr;
        ex_alu_result = alu; ex_pred_taken = pt; ex_pred_target = ptg; flag_halt = halt;
        $display("txn t=%0t valid=%0b pc=%h imm=%h b/j/jr=%0b%0b%0b alu=%h pt=%0b ptg=%h halt=%0b",
                 $time, v, pc, imm, b, j, jr, alu, pt, ptg, halt);
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_pc = '0; ex_imm = '0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
        ex_alu_result = '0; ex_pred_taken = 0; ex_pred_target = '0; flag_halt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; if_pc = 9'h040;
        drive_ex(1, 9'h010, 32'h20, 1, 0, 0, 32'h1, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got=%b exp=0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL rst_pred_target got=%h exp=0", pred_target); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got=%b exp=0", redirect); end
        checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL rst_br_count got=%0d exp=0", br_count); end
        checks++; if (mispred_count !== 32'd0) begin errors++; $display("FAIL rst_mispred_count got=%0d exp=0", mispred_count); end
        reset = 0; drive_idle();
        @(posedge clk); #1;
        if_pc = 9'h010; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_release_pred got=%b exp=0", pred_taken); end
        $display("test_reset done");
    endtask

    task automatic test_branch_alloc();
        @(negedge clk);
        drive_ex(1, 9'h010, 32'h20, 1, 0, 0, 32'h1, 0, 32'h0, 0);
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL alloc_redirect got=%b exp=1", redirect); end
        checks++; if (redirect_pc !== 32'h30) begin errors++; $display("FAIL alloc_redirect_pc got=%h exp=00000030", redirect_pc); end
        checks++; if (pc_four !== 32'h14) begin errors++; $display("FAIL alloc_pc_four got=%h exp=00000014", pc_four); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (mispred_count !== 32'd1) begin errors++; $display("FAIL alloc_mispred got=%0d exp=1", mispred_count); end
        checks++; if (br_count !== 32'd1) begin errors++; $display("FAIL alloc_br got=%0d exp=1", br_count); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken got=%b exp=1", pred_taken); end
        checks++; if (pred_target !== 32'h30) begin errors++; $display("FAIL alloc_pred_target got=%h exp=00000030", pred_target); end
        $display("test_branch_alloc done");
    endtask

    task automatic test_counter_sat();
        // not taken while predicted taken: counter 10 -> 01
        @(negedge clk);
        drive_ex(1, 9'h010, 32'h20, 1, 0, 0, 32'h0, 1, 32'h30, 0);
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL nt1_redirect got=%b exp=1", redirect); end
        checks++; if (redirect_pc !== 32'h14) begin errors++; $display("FAIL nt1_redirect_pc got=%h exp=00000014", redirect_pc); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt1_pred got=%b exp=0", pred_taken); end
        checks++; if (mispred_count !== 32'd2) begin errors++; $display("FAIL nt1_mispred got=%0d exp=2", mispred_count); end
        // correctly predicted not taken: 01 -> 00
        @(negedge clk);
        drive_ex(1, 9'h010, 32'h20, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL nt2_redirect got=%b exp=0", redirect); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL nt2_redirect_pc got=%h exp=0", redirect_pc); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt2_pred got=%b exp=0", pred_taken); end
        // at the floor: stays 00
        @(negedge clk);
        drive_ex(1, 9'h010, 32'h20, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt3_floor_pred got=%b exp=0", pred_taken); end
        checks++; if (br_count !== 32'd4) begin errors++; $display("FAIL nt3_br got=%0d exp=4", br_count); end
        checks++; if (mispred_count !== 32'd2) begin errors++; $display("FAIL nt3_mispred got=%0d exp=2", mispred_count); end
        // taken: 00 -> 01, still predicts not taken
        @(negedge clk);
        drive_ex(1, 9'h010, 32'h20, 1, 0, 0, 32'h1, 0, 32'h0, 0);
        #1;
        checks++; if (redirect_pc !== 32'h30) begin errors++; $display("FAIL t1_redirect_pc got=%h exp=00000030", redirect_pc); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL t1_pred got=%b exp=0", pred_taken); end
        // taken again: 01 -> 10
        @(negedge clk);
        drive_ex(1, 9'h010, 32'h20, 1, 0, 0, 32'h1, 0, 32'h0, 0);
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL t2_pred got=%b exp=1", pred_taken); end
        checks++; if (pred_target !== 32'h30) begin errors++; $display("FAIL t2_target got=%h exp=00000030", pred_target); end
        checks++; if (br_count !== 32'd6) begin errors++; $display("FAIL t2_br got=%0d exp=6", br_count); end
        checks++; if (mispred_count !== 32'd4) begin errors++; $display("FAIL t2_mispred got=%0d exp=4", mispred_count); end
        $display("test_counter_sat done");
    endtask

    task automatic test_jalr();
        @(negedge clk);
        drive_ex(1, 9'h020, 32'h0, 0, 0, 1, 32'h101, 0, 32'h0, 0);
        #1;
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL jalr1_redirect_pc got=%h exp=00000100", redirect_pc); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h020; #1;
        checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL jalr1_target got=%h exp=00000100", pred_target); end
        @(negedge clk);
        drive_ex(1, 9'h020, 32'h0, 0, 0, 1, 32'h105, 1, 32'h100, 0);
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jalr2_redirect got=%b exp=1", redirect); end
        checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL jalr2_redirect_pc got=%h exp=00000104", redirect_pc); end
        checks++; if (pc_four !== 32'h24) begin errors++; $display("FAIL jalr2_pc_four got=%h exp=00000024", pc_four); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h020; #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jalr2_pred got=%b exp=1", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL jalr2_target got=%h exp=00000104", pred_target); end
        @(negedge clk);
        drive_ex(1, 9'h020, 32'h0, 0, 0, 1, 32'h105, 1, 32'h104, 0);
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL jalr3_redirect got=%b exp=0", redirect); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h020; #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jalr3_ceiling_pred got=%b exp=1", pred_taken); end
        checks++; if (br_count !== 32'd9) begin errors++; $display("FAIL jalr3_br got=%0d exp=9", br_count); end
        checks++; if (mispred_count !== 32'd6) begin errors++; $display("FAIL jalr3_mispred got=%0d exp=6", mispred_count); end
        $display("test_jalr done");
    endtask

    task automatic test_halt();
        @(negedge clk);
        drive_ex(1, 9'h010, 32'h40, 1, 0, 0, 32'h1, 0, 32'h0, 1);
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL halt_redirect got=%b exp=0", redirect); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL halt_redirect_pc got=%h exp=0", redirect_pc); end
        checks++; if (pc_four !== 32'h0) begin errors++; $display("FAIL halt_pc_four got=%h exp=0", pc_four); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (pred_target !== 32'h30) begin errors++; $display("FAIL halt_target got=%h exp=00000030", pred_target); end
        checks++; if (br_count !== 32'd9) begin errors++; $display("FAIL halt_br got=%0d exp=9", br_count); end
        checks++; if (mispred_count !== 32'd6) begin errors++; $display("FAIL halt_mispred got=%0d exp=6", mispred_count); end
        @(negedge clk);
        drive_ex(0, 9'h010, 32'h40, 1, 0, 0, 32'h1, 0, 32'h0, 0);
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL invalid_redirect got=%b exp=0", redirect); end
        checks++; if (pc_four !== 32'h14) begin errors++; $display("FAIL invalid_pc_four got=%h exp=00000014", pc_four); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h010; #1;
        checks++; if (pred_target !== 32'h30) begin errors++; $display("FAIL invalid_target got=%h exp=00000030", pred_target); end
        checks++; if (br_count !== 32'd9) begin errors++; $display("FAIL invalid_br got=%0d exp=9", br_count); end
        $display("test_halt done");
    endtask

    task automatic test_alias();
        @(negedge clk);
        drive_ex(1, 9'h050, 32'h100, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        if_pc = 9'h050; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_same_cycle_pred got=%b exp=0", pred_taken); end
        checks++; if (redirect_pc !== 32'h150) begin errors++; $display("FAIL alias_redirect_pc got=%h exp=00000150", redirect_pc); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h050; #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_pred got=%b exp=1", pred_taken); end
        checks++; if (pred_target !== 32'h150) begin errors++; $display("FAIL alias_new_target got=%h exp=00000150", pred_target); end
        if_pc = 9'h010; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted_pred got=%b exp=0", pred_taken); end
        checks++; if (br_count !== 32'd10) begin errors++; $display("FAIL alias_br got=%0d exp=10", br_count); end
        checks++; if (mispred_count !== 32'd7) begin errors++; $display("FAIL alias_mispred got=%0d exp=7", mispred_count); end
        $display("test_alias done");
    endtask

    task automatic test_priority_wrap();
        @(negedge clk);
        drive_ex(1, 9'h0C0, 32'h10, 1, 1, 1, 32'h81, 0, 32'h0, 0);
        #1;
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL prio_redirect_pc got=%h exp=00000080", redirect_pc); end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        drive_ex(1, 9'h004, 32'hFFFF_FFF8, 1, 0, 0, 32'h1, 0, 32'h0, 0);
        #1;
        checks++; if (redirect_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect_pc got=%h exp=fffffffc", redirect_pc); end
        @(posedge clk); #1;
        drive_idle(); if_pc = 9'h004; #1;
        checks++; if (pred_target !== 32'h1FC) begin errors++; $display("FAIL wrap_target got=%h exp=000001fc", pred_target); end
        checks++; if (br_count !== 32'd12) begin errors++; $display("FAIL wrap_br got=%0d exp=12", br_count); end
        checks++; if (mispred_count !== 32'd9) begin errors++; $display("FAIL wrap_mispred got=%0d exp=9", mispred_count); end
        $display("test_priority_wrap done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1; drive_idle();
        @(posedge clk); #1;
        @(negedge clk);
        reset = 0; if_pc = 9'h050; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rstmid_pred got=%b exp=0", pred_taken); end
        checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL rstmid_br got=%0d exp=0", br_count); end
        checks++; if (mispred_count !== 32'd0) begin errors++; $display("FAIL rstmid_mispred got=%0d exp=0", mispred_count); end
        if_pc = 9'h020; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rstmid_pred_020 got=%b exp=0", pred_taken); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1; if_pc = '0; drive_idle();
        test_reset();
        test_branch_alloc();
        test_counter_sat();
        test_jalr();
        test_halt();
        test_alias();
        test_priority_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised branch resolution and prediction unit for the RV32I pipeline. Fetch side: combinational lookup of a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, giving predicted direction and target for the fetch PC. Execute side: resolves branch/JAL/JALR, computes PC+4 and the actual target, flags mispredictions, and drives the redirect. Table updates and performance counters are clocked.

Parameters:
PC_W, 9, PC width in bits; all PCs are zero-extended to 32 bits on outputs.
BTB_ENTRIES, 16, number of BTB/BHT entries; power of two, >= 2; IDX_W = log2(BTB_ENTRIES).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_pc  in  PC_W  fetch-stage PC for lookup
pred_taken  out  1  prediction for if_pc: taken
pred_target  out  32  predicted target, zero-extended; 0 when pred_taken=0
ex_valid  in  1  execute-stage instruction valid
ex_pc  in  PC_W  execute-stage PC
ex_imm  in  32  sign-extended immediate
ex_branch  in  1  conditional branch
ex_jal  in  1  JAL
ex_jalr  in  1  JALR
ex_alu_result  in  32  ALU result; bit0 is the branch condition; full value is the JALR target
ex_pred_taken  in  1  prediction carried down from fetch
ex_pred_target  in  32  predicted target carried down from fetch
flag_halt  in  1  halt: suppresses redirect and table/counter updates
pc_four  out  32  ex_pc+4; 0 when flag_halt=1
redirect  out  1  mispredict: flush and redirect fetch
redirect_pc  out  32  correct next PC
br_count  out  CNT_W  resolved control-transfer count
mispred_count  out  CNT_W  misprediction count

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2] (empty if PC_W <= IDX_W+2; a hit then needs only valid). Entry = {valid, tag, target[PC_W-1:0], ctr[1:0]}.
- Lookup (combinational): hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = pred_taken ? {0, target} : 0. Lookup reads pre-edge contents; no bypass from a same-cycle update.
- Resolve (combinational), ctl = ex_valid && (ex_branch || ex_jal || ex_jalr) && !flag_halt:
  - actual_taken = ex_jal || ex_jalr || (ex_branch && ex_alu_result[0]).
  - actual_target = ex_jalr ? {ex_alu_result[31:1],1'b0} : {0,ex_pc} + ex_imm (32-bit, wraps mod 2^32).
  - mispredict = actual_taken != ex_pred_taken, or both taken and actual_target != ex_pred_target.
  - redirect = ctl && mispredict; redirect_pc = actual_taken ? actual_target : pc_four; redirect_pc = 0 when redirect=0.
  - Priority if several of ex_jal/ex_jalr/ex_branch are set: jalr > jal > branch.
- Update (posedge clk, when ctl), on entry at ex_pc index:
  - Hit: ctr saturating +1 if taken, -1 if not (00 floor, 11 ceiling); target <= actual_target[PC_W-1:0] if taken.
  - Miss and taken: allocate (overwrite): valid=1, tag, target; ctr=10 for branch, 11 for JAL/JALR.
  - Miss and not taken: no change.
  - br_count += 1; mispred_count += 1 if mispredict; both wrap at 2^CNT_W.
- Reset (synchronous): all valid=0, all ctr=01, targets/tags=0, both counters=0. While reset=1: pred_taken=0, redirect=0, no updates. Reset mid-operation discards all history; the first cycle after release sees an empty BTB.
- ex_valid=0 or flag_halt=1: no updates, redirect=0; pc_four=0 only under flag_halt.
- Same-index lookup and update in one cycle: the lookup returns old state; the new state is visible from the next cycle.

Test Plan:
1. Reset, if_pc=0x040 -> pred_taken=0, pred_target=0, counters 0; cycle after release still pred_taken=0.
2. Branch at ex_pc=0x010, imm=0x20, alu[0]=1, ex_pred_taken=0 -> redirect=1, redirect_pc=0x30, mispred_count=1; next cycle if_pc=0x010 -> pred_taken=1, pred_target=0x30 (ctr=10).
3. Same branch resolved not-taken twice, ex_pred_taken=1/target=0x30 -> first: redirect=1, redirect_pc=0x14, ctr=01; lookup then pred_taken=0; second: redirect=0, ctr=00; a further not-taken keeps ctr=00.
4. JALR ex_pc=0x020, alu=0x0000_0105, ex_pred_taken=1, ex_pred_target=0x100 -> actual 0x104, redirect=1, redirect_pc=0x104; BTB target updated; ctr stays 11.
5. flag_halt=1 with a mispredicting branch -> redirect=0, pc_four=0, counters and BTB unchanged.
6. Aliasing PCs 0x010 and 0x050 (BTB_ENTRIES=16; same index, tags differ): taken JAL at 0x050 evicts the 0x010 entry; if_pc=0x010 -> pred_taken=0. Same-cycle lookup/update at 0x050 returns the old entry.
